i2c_cmd_sequencer: RTL and testbench
====================================

Name: i2c_cmd_sequencer

Overview:
- Avalon-MM master that drives the i2c master's 2-bit-address / 8-bit-data Avalon slave port and its interrupt line.
- Sits directly upstream of the i2c master. Executes a command list from an external synchronous ROM, such as a codec register init table, with no CPU involved.
- Each command writes a register, polls a register until a masked match, waits for the irq, or ends the list.
- Reports done or error with the index of the failing command.

Parameters:
- CMD_ADR_W, 8, width of the command ROM address; maximum list length is 2**CMD_ADR_W entries.
- TIMEOUT_CYCLES, 1_000_000, cycles one POLL or WAIT_IRQ may wait before error.
- RD_LATENCY, 1, fixed cycles from avm_read to valid avm_readdata; must be 1..3.

Ports:
- csi_clk  in  1  master clock.
- rsi_reset  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; starts execution at ROM entry 0. Ignored while busy.
- busy  out  1  high from the cycle after start until done or err is asserted.
- done  out  1  one-cycle pulse when an END command is reached.
- err  out  1  one-cycle pulse on timeout or ROM overrun.
- errIdx  out  CMD_ADR_W  index of the failing command; held until the next start.
- cmdAdr  out  CMD_ADR_W  command ROM address.
- cmdData  in  20  ROM word, valid 1 cycle after cmdAdr. Fields:
  - [19:18] op: 0 WR, 1 POLL, 2 WAIT_IRQ, 3 END.
  - [17:16] adr.
  - [15:8] data.
  - [7:0] mask.
- avm_address  out  2  to the i2c master avsAdr.
- avm_write  out  1  single-cycle write strobe.
- avm_writedata  out  8  write data.
- avm_read  out  1  single-cycle read strobe.
- avm_readdata  in  8  read data, valid RD_LATENCY cycles after avm_read.
- avm_irq  in  1  level interrupt from the i2c master.

Behaviour:
- Reset values:
  - busy, done, err, avm_write, avm_read: 0.
  - avm_address, avm_writedata, cmdAdr, errIdx: 0.
  - State: IDLE.
  - Reset mid-operation aborts immediately; no further bus cycles are issued.
- Outputs: all registered; avm_write and avm_read are never high in the same cycle.
- FSM states and transitions:
  - IDLE: on start, set pc=0, busy=1, cmdAdr=0, go to FETCH.
  - FETCH: wait one cycle for ROM latency, go to DECODE.
  - DECODE: latch the command fields, clear the timeout counter, then branch on op:
    - WR: go to WRITE.
    - POLL: go to READ.
    - WAIT_IRQ: go to IRQWAIT.
    - END: go to FINISH.
  - WRITE: avm_write=1 for exactly one cycle with avm_address=adr and avm_writedata=data; then go to NEXT.
  - READ: avm_read=1 for one cycle with avm_address=adr; go to RDWAIT.
  - RDWAIT: count RD_LATENCY cycles, sample avm_readdata, go to CHECK.
  - CHECK: compare (rd & mask) against (data & mask).
    - Match: go to NEXT.
    - Mismatch with timeout not expired: go to READ (a re-poll).
    - Mismatch with timeout expired: go to FAIL.
    - mask=0 always matches.
  - IRQWAIT: if avm_irq=1, go to NEXT. Otherwise increment the counter; when it reaches TIMEOUT_CYCLES, go to FAIL.
  - NEXT:
    - If pc is the last ROM index, go to FAIL (overrun: no END found).
    - Otherwise pc=pc+1, cmdAdr=pc+1, go to FETCH.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
  - FAIL: err=1 for one cycle, errIdx=pc, busy=0, go to IDLE.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Counts every cycle in READ/RDWAIT/CHECK/IRQWAIT for the current command.
  - Saturates, never wraps.
  - Cleared in DECODE.
- Timing:
  - Latency from start to the first avm_write for a WR at entry 0 is 4 cycles (IDLE→FETCH→DECODE→WRITE).
  - Each WR command occupies 4 cycles.
- Simultaneous events:
  - start in the same cycle as done or err is ignored.
  - avm_irq high on the IRQWAIT entry cycle completes the command with no timeout increment.
  - A POLL match in the same cycle the timeout expires counts as a match.
- The irq is not cleared by the sequencer; clearing it requires an explicit WR command in the list.

Decomposition:
- Package i2c_seq_pkg holds:
  - Op enum (OP_WR, OP_POLL, OP_WAIT_IRQ, OP_END).
  - Packed struct cmd_t matching the 20-bit ROM layout.
  - FSM state enum.
  - Constant CMD_W=20.
- Sub-module i2c_seq_timer: saturating timeout counter with clr, en and expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- ROM {WR a1 d=0x34, WR a2 d=0x01, END}, pulse start → exactly two avm_write cycles with (1,0x34) then (2,0x01); first write 4 cycles after start; done pulse; busy low; err never asserted.
- POLL a3 data=0x80 mask=0x80; model returns 0x00 three times then 0x81 → four avm_read strobes, RD_LATENCY respected, then done.
- WAIT_IRQ with TIMEOUT_CYCLES=50 at ROM index 5, irq never asserted → err pulse after 50 waiting cycles, errIdx=5, no done, busy low.
- CMD_ADR_W=3, ROM of 8 WR commands with no END → 8 writes then err with errIdx=7; cmdAdr never wraps to 0.
- Assert rsi_reset during RDWAIT, release, pulse start → all outputs at reset values during reset; execution restarts at entry 0; no stray avm_read.
- start pulsed while busy, and again in the done cycle → both ignored; the bus access sequence is identical to the single-start run.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the i2c command sequencer: ROM word layout, opcodes and FSM states.
package i2c_seq_pkg;

  localparam int CMD_W = 20;

  typedef enum logic [1:0] {
    OP_WR       = 2'd0,
    OP_POLL     = 2'd1,
    OP_WAIT_IRQ = 2'd2,
    OP_END      = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] adr;
    logic [7:0] data;
    logic [7:0] mask;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_WRITE   = 4'd3,
    S_READ    = 4'd4,
    S_RDWAIT  = 4'd5,
    S_CHECK   = 4'd6,
    S_IRQWAIT = 4'd7,
    S_NEXT    = 4'd8,
    S_FINISH  = 4'd9,
    S_FAIL    = 4'd10
  } state_e;

  // A zero mask makes both sides zero, so it always matches.
  function automatic logic poll_match(input cmd_t cmd, input logic [7:0] rd);
    return ((rd & cmd.mask) == (cmd.data & cmd.mask));
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_timer.sv
// Saturating per-command timeout counter; cleared when a new command is decoded.
module i2c_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic expiring
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_LESS = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles, holding at LIMIT instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LIMIT)) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // expiring flags the cycle whose increment reaches LIMIT, so callers can leave on time.
  assign expired  = (count_r >= LIMIT);
  assign expiring = expired | (en & (count_r == LIMIT_LESS));

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Runs a command list from a synchronous ROM against the i2c master's Avalon slave port.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int CMD_ADR_W      = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RD_LATENCY     = 1
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CMD_ADR_W-1:0] errIdx,
  output logic [CMD_ADR_W-1:0] cmdAdr,
  input  logic [CMD_W-1:0]     cmdData,
  output logic [1:0]           avm_address,
  output logic                 avm_write,
  output logic [7:0]           avm_writedata,
  output logic                 avm_read,
  input  logic [7:0]           avm_readdata,
  input  logic                 avm_irq
);

  localparam logic [1:0]           LAT     = 2'(RD_LATENCY);
  localparam logic [CMD_ADR_W-1:0] LAST_PC = '1;
  localparam logic [CMD_ADR_W-1:0] PC_ONE  = CMD_ADR_W'(1);

  state_e               state_r;
  cmd_t                 cmd_r;
  logic [CMD_ADR_W-1:0] pc_r;
  logic [7:0]           rd_r;
  logic [1:0]           lat_r;
  cmd_t                 rom_cmd_s;
  logic                 timer_clr_s;
  logic                 timer_en_s;
  logic                 expired_s;
  logic                 expiring_s;

  assign rom_cmd_s = cmd_t'(cmdData);

  // Timer runs while a POLL or WAIT_IRQ is pending; an irq-ready cycle is not counted.
  always_comb begin
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    case (state_r)
      S_DECODE:                   timer_clr_s = 1'b1;
      S_READ, S_RDWAIT, S_CHECK:  timer_en_s  = 1'b1;
      S_IRQWAIT:                  timer_en_s  = ~avm_irq;
      default: begin
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
      end
    endcase
  end

  i2c_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (csi_clk),
    .rst      (rsi_reset),
    .clr      (timer_clr_s),
    .en       (timer_en_s),
    .expired  (expired_s),
    .expiring (expiring_s)
  );

  // Sequencer FSM with registered bus strobes and status.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_r       <= S_IDLE;
      cmd_r         <= '0;
      pc_r          <= '0;
      rd_r          <= 8'h00;
      lat_r         <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      errIdx        <= '0;
      cmdAdr        <= '0;
      avm_address   <= 2'd0;
      avm_write     <= 1'b0;
      avm_writedata <= 8'h00;
      avm_read      <= 1'b0;
    end else begin
      avm_write <= 1'b0;
      avm_read  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // done/err still high means we only just finished; a start now is dropped.
          if (start && !done && !err) begin
            pc_r    <= '0;
            cmdAdr  <= '0;
            errIdx  <= '0;
            busy    <= 1'b1;
            state_r <= S_FETCH;
          end
        end
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          cmd_r <= rom_cmd_s;
          case (rom_cmd_s.op)
            OP_WR:       state_r <= S_WRITE;
            OP_POLL:     state_r <= S_READ;
            OP_WAIT_IRQ: state_r <= S_IRQWAIT;
            OP_END:      state_r <= S_FINISH;
            default:     state_r <= S_FAIL;
          endcase
        end
        S_WRITE: begin
          avm_write     <= 1'b1;
          avm_address   <= cmd_r.adr;
          avm_writedata <= cmd_r.data;
          state_r       <= S_NEXT;
        end
        S_READ: begin
          avm_read    <= 1'b1;
          avm_address <= cmd_r.adr;
          lat_r       <= 2'd0;
          state_r     <= S_RDWAIT;
        end
        S_RDWAIT: begin
          // lat_r is 0 in the strobe cycle, so data is valid once it equals LAT.
          if (lat_r == LAT) begin
            rd_r    <= avm_readdata;
            state_r <= S_CHECK;
          end else begin
            lat_r <= lat_r + 2'd1;
          end
        end
        S_CHECK: begin
          if (poll_match(cmd_r, rd_r)) begin
            state_r <= S_NEXT;
          end else if (expired_s) begin
            state_r <= S_FAIL;
          end else begin
            state_r <= S_READ;
          end
        end
        S_IRQWAIT: begin
          if (avm_irq) begin
            state_r <= S_NEXT;
          end else if (expiring_s) begin
            state_r <= S_FAIL;
          end
        end
        S_NEXT: begin
          if (pc_r == LAST_PC) begin
            state_r <= S_FAIL;
          end else begin
            pc_r    <= pc_r + PC_ONE;
            cmdAdr  <= pc_r + PC_ONE;
            state_r <= S_FETCH;
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        S_FAIL: begin
          err     <= 1'b1;
          errIdx  <= pc_r;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: ROM and i2c-slave models, event log, hand-computed timing.
module tb_i2c_cmd_sequencer;
  import i2c_seq_pkg::*;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err, avm_write, avm_read;
  logic [AW-1:0] errIdx, cmdAdr;
  logic [19:0]   cmdData = 20'h0;
  logic [1:0]    avm_address;
  logic [7:0]    avm_writedata;
  logic [7:0]    avm_readdata = 8'h00;
  logic          avm_irq = 1'b0;

  i2c_cmd_sequencer #(.CMD_ADR_W(AW), .TIMEOUT_CYCLES(50), .RD_LATENCY(2)) dut (
    .csi_clk(clk), .rsi_reset(rst), .start(start), .busy(busy), .done(done), .err(err),
    .errIdx(errIdx), .cmdAdr(cmdAdr), .cmdData(cmdData), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_irq(avm_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, c0 = 0;
  logic [19:0] rom [8];
  logic [7:0]  resp [8];
  logic        rd_pend = 1'b0;
  int          ridx = 0;

  int          n_wr, n_rd, n_done, n_err, done_cyc, err_cyc;
  int          wr_cyc [16];
  int          rd_cyc [16];
  logic [1:0]  wr_adr [16];
  logic [1:0]  rd_adr [16];
  logic [7:0]  wr_dat [16];
  logic        both, wrapped, seen_nz;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) cmdData <= rom[cmdAdr];

  // Slave with two-cycle read latency: data valid in the second cycle after the strobe.
  always @(posedge clk) begin
    rd_pend <= avm_read;
    if (rd_pend) begin
      avm_readdata <= resp[ridx[2:0]];
      ridx <= ridx + 1;
    end else begin
      avm_readdata <= 8'h00;
    end
  end

  always @(negedge clk) begin
    if (avm_write && avm_read) both <= 1'b1;
    if (avm_write) begin
      if (n_wr < 16) begin
        wr_cyc[n_wr] <= cyc - c0; wr_adr[n_wr] <= avm_address; wr_dat[n_wr] <= avm_writedata;
      end
      n_wr <= n_wr + 1;
    end
    if (avm_read) begin
      if (n_rd < 16) begin
        rd_cyc[n_rd] <= cyc - c0; rd_adr[n_rd] <= avm_address;
      end
      n_rd <= n_rd + 1;
    end
    if (done) begin n_done <= n_done + 1; done_cyc <= cyc - c0; end
    if (err)  begin n_err <= n_err + 1;  err_cyc <= cyc - c0; end
    if (busy && cmdAdr != '0) seen_nz <= 1'b1;
    if (busy && seen_nz && cmdAdr == '0) wrapped <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [19:0] mk(input op_e op, input logic [1:0] adr,
                                     input logic [7:0] data, input logic [7:0] mask);
    return {op, adr, data, mask};
  endfunction

  task automatic clear_log();
    n_wr = 0; n_rd = 0; n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
    both = 1'b0; wrapped = 1'b0; seen_nz = 1'b0; ridx = 0;
  endtask

  task automatic fill_rom(input logic [19:0] w);
    for (int i = 0; i < 8; i++) rom[i] = w;
  endtask

  // Start is high for cycle 0; returns #1 into cycle 1.
  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1; c0 = cyc;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {11'd0, busy, done, err, avm_write, avm_read, avm_address, avm_writedata,
                cmdAdr, errIdx}, 32'd0);
  endtask

  initial begin
    fill_rom(mk(OP_END, 2'd0, 8'h00, 8'h00));
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset_outputs");
    rst = 1'b0;
    run(2);

    // Two writes then END.
    rom[0] = mk(OP_WR, 2'd1, 8'h34, 8'h00);
    rom[1] = mk(OP_WR, 2'd2, 8'h01, 8'h00);
    rom[2] = mk(OP_END, 2'd0, 8'h00, 8'h00);
    clear_log();
    pulse_start();
    @(negedge clk);
    check("wr_busy_cycle1", busy, 1);
    run(30);
    check("wr_count", n_wr, 2);
    check("wr0_cycle", wr_cyc[0], 4);
    check("wr0_adr_dat", {wr_adr[0], wr_dat[0]}, {2'd1, 8'h34});
    check("wr1_cycle", wr_cyc[1], 8);
    check("wr1_adr_dat", {wr_adr[1], wr_dat[1]}, {2'd2, 8'h01});
    check("wr_done_count", n_done, 1);
    check("wr_done_cycle", done_cyc, 12);
    check("wr_no_err", n_err, 0);
    check("wr_busy_end", busy, 0);

    // Same list with start re-pulsed while busy and in the done cycle.
    clear_log();
    pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("dbl_done_at_12", done, 1);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    run(20);
    check("dbl_wr_count", n_wr, 2);
    check("dbl_wr_cycles", {wr_cyc[0][15:0], wr_cyc[1][15:0]}, {16'd4, 16'd8});
    check("dbl_done_count", n_done, 1);
    check("dbl_busy_end", busy, 0);

    // POLL until bit 7 set: three misses then a hit.
    rom[0] = mk(OP_POLL, 2'd3, 8'h80, 8'h80);
    rom[1] = mk(OP_END, 2'd0, 8'h00, 8'h00);
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00; resp[3] = 8'h81;
    clear_log();
    pulse_start();
    run(40);
    check("poll_reads", n_rd, 4);
    check("poll_rd0_cycle", rd_cyc[0], 4);
    check("poll_rd1_cycle", rd_cyc[1], 9);
    check("poll_rd3_cycle", rd_cyc[3], 19);
    check("poll_rd_adr", rd_adr[3], 3);
    check("poll_done_cycle", done_cyc, 27);
    check("poll_no_err_wr", {n_err[15:0], n_wr[15:0]}, 32'd0);
    check("poll_no_overlap", both, 0);

    // WAIT_IRQ at index 5 with irq never raised: 50 waiting cycles then err.
    for (int i = 0; i < 5; i++) rom[i] = mk(OP_WR, 2'd0, 8'(i), 8'h00);
    rom[5] = mk(OP_WAIT_IRQ, 2'd0, 8'h00, 8'h00);
    rom[6] = mk(OP_END, 2'd0, 8'h00, 8'h00);
    avm_irq = 1'b0;
    clear_log();
    pulse_start();
    run(90);
    check("irq_wr_count", n_wr, 5);
    check("irq_err_count", n_err, 1);
    check("irq_err_cycle", err_cyc, 74);
    check("irq_err_idx", errIdx, 5);
    check("irq_no_done", n_done, 0);
    check("irq_busy_end", busy, 0);

    // irq already high on IRQWAIT entry completes immediately.
    rom[0] = mk(OP_WAIT_IRQ, 2'd0, 8'h00, 8'h00);
    rom[1] = mk(OP_END, 2'd0, 8'h00, 8'h00);
    avm_irq = 1'b1;
    clear_log();
    pulse_start();
    run(20);
    avm_irq = 1'b0;
    check("irqhi_done_cycle", done_cyc, 8);
    check("irqhi_no_err", n_err, 0);

    // Eight writes and no END: overrun at the last index.
    for (int i = 0; i < 8; i++) rom[i] = mk(OP_WR, 2'(i), 8'(8'h10 + i), 8'h00);
    clear_log();
    pulse_start();
    run(50);
    check("ovr_wr_count", n_wr, 8);
    check("ovr_wr7", {wr_adr[7], wr_dat[7]}, {2'd3, 8'h17});
    check("ovr_wr7_cycle", wr_cyc[7], 32);
    check("ovr_err_cycle", err_cyc, 34);
    check("ovr_err_idx", errIdx, 7);
    check("ovr_no_wrap", wrapped, 0);
    check("ovr_no_done", n_done, 0);

    // Reset during RDWAIT, then a fresh run from entry 0.
    rom[0] = mk(OP_POLL, 2'd1, 8'h01, 8'h01);
    rom[1] = mk(OP_END, 2'd0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    clear_log();
    pulse_start();
    run(4);
    check("rst_read_before", n_rd, 1);
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid_outputs");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst_held_outputs");
    rst = 1'b0;
    rom[0] = mk(OP_WR, 2'd2, 8'h55, 8'h00);
    clear_log();
    pulse_start();
    run(20);
    check("rst_no_stray_read", n_rd, 0);
    check("rst_restart_wr", {wr_adr[0], wr_dat[0]}, {2'd2, 8'h55});
    check("rst_restart_cycle", wr_cyc[0], 4);
    check("rst_restart_done", n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
